// File: rtl/ecc_point_alu.sv
// Affine elliptic-curve point ALU (add / subtract / double) over GF(P_MOD).
// One serial MSB-first modular multiplier and one binary extended-Euclid inverter, sequenced by an FSM.
module ecc_point_alu #(
  parameter int          W      = 64,
  parameter logic [W-1:0] P_MOD  = 64'hFFFFFFFFFFFFFFC5,
  parameter logic [W-1:0] A_COEF = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_en,
  input  logic [1:0]   alu_op,
  input  logic [2*W:0] alu_P,
  input  logic [2*W:0] alu_Q,
  output logic [2*W:0] alu_R,
  output logic         alu_done,
  output logic         alu_busy
);
  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_DBL = 2'b10, OP_RSV = 2'b11;

  typedef struct packed {
    logic         inf;
    logic [W-1:0] y;
    logic [W-1:0] x;
  } point_t;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_NUM, S_INV, S_LAM, S_SQ, S_X3, S_Y3, S_FIN, S_DONE
  } state_t;

  localparam point_t PT_INF = '{inf: 1'b1, y: '0, x: '0};

  function automatic logic [W-1:0] madd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] msub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W]) d = d + {1'b0, P_MOD};
    return d[W-1:0];
  endfunction

  // x/2 mod P: odd values become even by adding the (odd) modulus first.
  function automatic logic [W-1:0] mhalf(input logic [W-1:0] x);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, P_MOD}) : {1'b0, x};
    return s[W:1];
  endfunction

  state_t       state_q, state_d;
  point_t       pt_q, pt_d, qt_q, qt_d;
  logic [1:0]   op_q, op_d;
  logic         dbl_q, dbl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] acc_q, acc_d, bsh_q, bsh_d;
  logic [W-1:0] num_q, num_d, lam_q, lam_d, x3_q, x3_d, dif_q, dif_d;
  logic [W-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
  logic [2*W:0] r_q, r_d;
  logic         done_q, done_d;

  logic         mul_run, mul_last, mul_fin;
  logic [W-1:0] mul_a, mul_b, acc_nx, acc_dbl, x3n, t3;
  point_t       qin;

  assign alu_R    = r_q;
  assign alu_done = done_q;
  assign alu_busy = (state_q != S_IDLE);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      S_NUM:   begin mul_a = pt_q.x; mul_b = pt_q.x; end
      S_LAM:   begin mul_a = num_q;  mul_b = x1_q;   end
      S_SQ:    begin mul_a = lam_q;  mul_b = lam_q;  end
      S_Y3:    begin mul_a = lam_q;  mul_b = dif_q;  end
      default: ;
    endcase
  end

  assign mul_run  = (state_q == S_NUM && dbl_q) || state_q == S_LAM ||
                    state_q == S_SQ || state_q == S_Y3;
  assign mul_last = (cnt_q == CW'(W));
  assign mul_fin  = mul_run && mul_last;
  // One multiplier step: acc = 2*acc + bit*a, each add reduced by a single conditional subtract.
  assign acc_dbl  = madd(acc_q, acc_q);
  assign acc_nx   = bsh_q[W-1] ? madd(acc_dbl, mul_a) : acc_dbl;

  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    qt_d    = qt_q;
    op_d    = op_q;
    dbl_d   = dbl_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bsh_d   = bsh_q;
    num_d   = num_q;
    lam_d   = lam_q;
    x3_d    = x3_q;
    dif_d   = dif_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    r_d     = r_q;
    done_d  = 1'b0;
    qin     = alu_Q;
    x3n     = '0;
    t3      = '0;

    // Cycle 0 of a multiply clears the accumulator; cycles 1..W consume b MSB-first.
    if (mul_run) begin
      if (cnt_q == '0) begin
        acc_d = '0;
        bsh_d = mul_b;
        cnt_d = CW'(1);
      end else begin
        acc_d = acc_nx;
        bsh_d = bsh_q << 1;
        cnt_d = mul_last ? '0 : cnt_q + CW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (alu_en) begin
          if (alu_op == OP_SUB) qin.y = (qin.y == '0) ? '0 : P_MOD - qin.y;
          op_d    = alu_op;
          pt_d    = alu_P;
          qt_d    = qin;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        dbl_d   = 1'b0;
        state_d = S_DONE;
        done_d  = 1'b1;
        if (op_q == OP_RSV) r_d = pt_q;
        else if (op_q == OP_DBL) begin
          if (pt_q.inf || pt_q.y == '0) r_d = PT_INF;
          else begin dbl_d = 1'b1; state_d = S_NUM; done_d = 1'b0; end
        end
        else if (pt_q.inf) r_d = qt_q;
        else if (qt_q.inf) r_d = pt_q;
        else if (pt_q.x == qt_q.x) begin
          // Equal x: either P == -Q' (infinity) or P == Q' (doubling, which is infinity at y == 0).
          if (pt_q.y != qt_q.y || pt_q.y == '0) r_d = PT_INF;
          else begin dbl_d = 1'b1; state_d = S_NUM; done_d = 1'b0; end
        end
        else begin state_d = S_NUM; done_d = 1'b0; end
      end
      S_NUM: begin
        if (!dbl_q) begin
          num_d   = msub(qt_q.y, pt_q.y);
          u_d     = msub(qt_q.x, pt_q.x);
          v_d     = P_MOD;
          x1_d    = W'(1);
          x2_d    = '0;
          state_d = S_INV;
        end else if (mul_fin) begin
          t3      = madd(madd(acc_nx, acc_nx), acc_nx);
          num_d   = madd(t3, A_COEF);
          u_d     = madd(pt_q.y, pt_q.y);
          v_d     = P_MOD;
          x1_d    = W'(1);
          x2_d    = '0;
          state_d = S_INV;
        end
      end
      S_INV: begin
        // Invariants: x1*den == u, x2*den == v (mod P); the inverse sits beside whichever reaches 1.
        if (u_q == W'(1)) state_d = S_LAM;
        else if (v_q == W'(1)) begin
          x1_d    = x2_q;
          state_d = S_LAM;
        end
        else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = mhalf(x1_q);
        end
        else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = mhalf(x2_q);
        end
        else if (u_q >= v_q) begin
          u_d  = (u_q - v_q) >> 1;
          x1_d = mhalf(msub(x1_q, x2_q));
        end
        else begin
          v_d  = (v_q - u_q) >> 1;
          x2_d = mhalf(msub(x2_q, x1_q));
        end
      end
      S_LAM: if (mul_fin) begin lam_d = acc_nx; state_d = S_SQ; end
      S_SQ:  if (mul_fin) state_d = S_X3;
      S_X3: begin
        x3n     = msub(msub(acc_q, pt_q.x), dbl_q ? pt_q.x : qt_q.x);
        x3_d    = x3n;
        dif_d   = msub(pt_q.x, x3n);
        state_d = S_Y3;
      end
      S_Y3:  if (mul_fin) state_d = S_FIN;
      S_FIN: begin
        r_d     = {1'b0, msub(acc_q, pt_q.y), x3_q};
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pt_q    <= '0;
      qt_q    <= '0;
      op_q    <= '0;
      dbl_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bsh_q   <= '0;
      num_q   <= '0;
      lam_q   <= '0;
      x3_q    <= '0;
      dif_q   <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      qt_q    <= qt_d;
      op_q    <= op_d;
      dbl_q   <= dbl_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bsh_q   <= bsh_d;
      num_q   <= num_d;
      lam_q   <= lam_d;
      x3_q    <= x3_d;
      dif_q   <= dif_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_ecc_point_alu.sv
// Bench for ecc_point_alu on the toy curve y^2 = x^3 + 2x + 2 over GF(17) (G=(5,1), order 19).
// Expected points come from textbook affine group-law arithmetic on small integers.
module tb_ecc_point_alu;
  localparam int W  = 64;
  localparam int PM = 17;
  localparam int AC = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           alu_en;
  logic [1:0]     alu_op;
  logic [2*W:0]   alu_P, alu_Q, alu_R;
  logic           alu_done, alu_busy;

  int tests = 0;
  int fails = 0;

  ecc_point_alu #(.W(W), .P_MOD(64'd17), .A_COEF(64'd2)) dut (
    .clk(clk), .rst(rst), .alu_en(alu_en), .alu_op(alu_op), .alu_P(alu_P),
    .alu_Q(alu_Q), .alu_R(alu_R), .alu_done(alu_done), .alu_busy(alu_busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit inf; int x; int y; } pt_t;
  typedef struct { logic [1:0] op; logic [2*W:0] p; logic [2*W:0] q; logic [2*W:0] r; } vec_t;

  localparam logic [2*W:0] INF = {1'b1, 128'b0};

  function automatic logic [2*W:0] mk(input int x, input int y);
    return {1'b0, 64'(y), 64'(x)};
  endfunction

  function automatic int md(input int a);
    int r;
    r = a % PM;
    if (r < 0) r += PM;
    return r;
  endfunction

  function automatic int minv(input int a);
    int r;
    r = 1;
    for (int i = 0; i < PM - 2; i++) r = md(r * a);
    return r;
  endfunction

  function automatic logic [2*W:0] enc(input pt_t p);
    if (p.inf) return INF;
    return mk(p.x, p.y);
  endfunction

  function automatic pt_t pinf();
    pt_t r;
    r.inf = 1'b1; r.x = 0; r.y = 0;
    return r;
  endfunction

  function automatic pt_t pneg(input pt_t p);
    pt_t r;
    r = p;
    if (!p.inf) r.y = md(-p.y);
    return r;
  endfunction

  function automatic pt_t pdbl(input pt_t p);
    pt_t r;
    int  lam;
    if (p.inf || p.y == 0) return pinf();
    lam   = md(md(3 * p.x * p.x + AC) * minv(md(2 * p.y)));
    r.inf = 1'b0;
    r.x   = md(lam * lam - 2 * p.x);
    r.y   = md(lam * (p.x - r.x) - p.y);
    return r;
  endfunction

  function automatic pt_t padd(input pt_t p, input pt_t q);
    pt_t r;
    int  lam;
    if (p.inf) return q;
    if (q.inf) return p;
    if (p.x == q.x) return (md(p.y + q.y) == 0) ? pinf() : pdbl(p);
    lam   = md(md(q.y - p.y) * minv(md(q.x - p.x)));
    r.inf = 1'b0;
    r.x   = md(lam * lam - p.x - q.x);
    r.y   = md(lam * (p.x - r.x) - p.y);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [2*W:0] act, input logic [2*W:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pulses alu_en for one cycle, then waits (bounded) for alu_done; lat counts cycles from en.
  task automatic run_op(input logic [1:0] op, input logic [2*W:0] p, input logic [2*W:0] q,
                        output logic [2*W:0] r, output int lat, output logic busy1);
    @(negedge clk);
    alu_en = 1'b1; alu_op = op; alu_P = p; alu_Q = q;
    @(negedge clk);
    alu_en = 1'b0;
    lat    = 1;
    busy1  = alu_busy;
    while (!alu_done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    if (!alu_done) chk("done_timeout", 129'(lat), 129'(0));
    r = alu_R;
  endtask

  vec_t         tv[11];
  pt_t          pts[$];
  pt_t          g, a, b, e, accp;
  logic [2*W:0] r;
  int           lat;
  logic         busy1;

  initial begin
    tv[0]  = '{2'b10, mk(5, 1),  INF,       mk(6, 3)};
    tv[1]  = '{2'b00, mk(5, 1),  mk(6, 3),  mk(10, 6)};
    tv[2]  = '{2'b01, mk(10, 6), mk(6, 3),  mk(5, 1)};
    tv[3]  = '{2'b00, INF,       mk(5, 1),  mk(5, 1)};
    tv[4]  = '{2'b00, mk(5, 1),  INF,       mk(5, 1)};
    tv[5]  = '{2'b00, mk(5, 1),  mk(5, 16), INF};
    tv[6]  = '{2'b01, mk(5, 1),  mk(5, 1),  INF};
    tv[7]  = '{2'b00, mk(5, 1),  mk(5, 1),  mk(6, 3)};
    tv[8]  = '{2'b11, mk(10, 6), mk(5, 1),  mk(10, 6)};
    tv[9]  = '{2'b01, INF,       mk(5, 1),  mk(5, 16)};
    tv[10] = '{2'b10, INF,       mk(6, 3),  INF};

    pts.push_back(pinf());
    for (int x = 0; x < PM; x++)
      for (int y = 0; y < PM; y++)
        if (md(y * y) == md(x * x * x + AC * x + 2)) begin
          e.inf = 1'b0; e.x = x; e.y = y;
          pts.push_back(e);
        end
    g.inf = 1'b0; g.x = 5; g.y = 1;

    rst = 1'b0; alu_en = 1'b0; alu_op = '0; alu_P = '0; alu_Q = '0;
    repeat (3) @(negedge clk);
    chk("reset_R", alu_R, '0);
    chk("reset_done_busy", {127'b0, alu_done, alu_busy}, '0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(tv[i].op, tv[i].p, tv[i].q, r, lat, busy1);
      chk($sformatf("vec%0d_R", i), r, tv[i].r);
      chk($sformatf("vec%0d_busy", i), 129'(busy1), 129'(1));
      @(negedge clk);
      chk($sformatf("vec%0d_after", i), {127'b0, alu_done, alu_busy}, '0);
      chk($sformatf("vec%0d_hold", i), alu_R, tv[i].r);
      if (i == 3 || i == 4 || i == 5) chk($sformatf("vec%0d_lat", i), 129'(lat), 129'(2));
      if (i == 0) chk("dbl_lat_bound", 129'(lat <= 4 * (W + 1) + 2 * W + 8 + W + 1), 129'(1));
    end

    // Random group operations against the affine model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      a  = pts[$urandom_range(0, pts.size() - 1)];
      b  = pts[$urandom_range(0, pts.size() - 1)];
      op = 2'($urandom_range(0, 3));
      case (op)
        2'b00:   e = padd(a, b);
        2'b01:   e = padd(a, pneg(b));
        2'b10:   e = pdbl(a);
        default: e = a;
      endcase
      run_op(op, enc(a), enc(b), r, lat, busy1);
      chk($sformatf("rnd%0d_op%0d", i, op), r, enc(e));
    end

    // 18 successive additions of G starting from infinity, then one more.
    accp = pinf();
    for (int i = 1; i <= 19; i++) begin
      run_op(2'b00, enc(accp), enc(g), r, lat, busy1);
      accp = padd(accp, g);
      if (i == 18) chk("chain_18G", r, mk(5, 16));
      if (i == 19) chk("chain_19G", r, INF);
      if (r !== enc(accp)) chk($sformatf("chain_step%0d", i), r, enc(accp));
      accp.inf = r[2*W]; accp.x = int'(r[W-1:0]); accp.y = int'(r[2*W-1:W]);
    end

    // alu_en while busy must be ignored.
    @(negedge clk);
    alu_en = 1'b1; alu_op = 2'b10; alu_P = mk(5, 1); alu_Q = INF;
    @(negedge clk);
    alu_en = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    alu_en = 1'b1; alu_op = 2'b00; alu_P = INF; alu_Q = mk(10, 6);
    @(negedge clk);
    alu_en = 1'b0; lat++;
    while (!alu_done && lat < 1000) begin @(negedge clk); lat++; end
    chk("ign_R", alu_R, mk(6, 3));
    chk("ign_long_lat", 129'(lat > 2 * W), 129'(1));
    @(negedge clk);
    chk("ign_after", {127'b0, alu_done, alu_busy}, '0);

    // Reset in the middle of a doubling (inverter phase).
    @(negedge clk);
    alu_en = 1'b1; alu_op = 2'b10; alu_P = mk(5, 1); alu_Q = INF;
    @(negedge clk);
    alu_en = 1'b0;
    repeat (66) @(negedge clk);
    chk("rst_mid_busy", 129'(alu_busy), 129'(1));
    rst = 1'b0;
    #1;
    chk("rst_mid_R", alu_R, '0);
    chk("rst_mid_flags", {127'b0, alu_done, alu_busy}, '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_release_idle", {127'b0, alu_done, alu_busy}, '0);
    run_op(2'b10, mk(5, 1), INF, r, lat, busy1);
    chk("rst_fresh_dbl", r, mk(6, 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
